// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared video constants and types for the pixel pipeline
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int DATA_W_DEF   = 8;
  localparam bit VS_POL_DEF   = 1'b1;

  // Sync outputs lag their inputs by this many pixel clocks; the Sobel
  // stage adds its own latency on top of this figure.
  localparam int SYNC_DLY = 2;

  typedef logic [DATA_W_DEF-1:0] pixel_t;

  // Address width for a line of n pixels, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - simple dual-port line buffer, synchronous read-first
module line_ram
  import vga_pkg::*;
#(
  parameter int DEPTH = H_ACTIVE_DEF,
  parameter int WIDTH = DATA_W_DEF,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic             pclk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // Contents are deliberately left unreset so this maps onto block RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge pclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port; a same-address write in the same cycle is seen next cycle.
  always_ff @(posedge pclk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/window_3x3_gen.sv
// rtl/window_3x3_gen.sv - 3x3 neighbourhood builder; WIN_BORDER_ZERO_EN zeroes off-frame taps
module window_3x3_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter bit VS_POL   = VS_POL_DEF
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_de,
  input  logic              pix_hsync,
  input  logic              pix_vsync,
  output logic [DATA_W-1:0] line11_data,
  output logic [DATA_W-1:0] line12_data,
  output logic [DATA_W-1:0] line13_data,
  output logic [DATA_W-1:0] line21_data,
  output logic [DATA_W-1:0] line22_data,
  output logic [DATA_W-1:0] line23_data,
  output logic [DATA_W-1:0] line31_data,
  output logic [DATA_W-1:0] line32_data,
  output logic [DATA_W-1:0] line33_data,
  output logic              de_flag_line,
  output logic              hsync_line,
  output logic              vsync_line
);

  localparam int            AW      = addr_w(H_ACTIVE);
  localparam logic [AW-1:0] COL_MAX = AW'(H_ACTIVE - 1);

  logic [AW-1:0]       col_cnt;
  logic [1:0]          row_cnt;
  logic [AW-1:0]       col_d1;
  logic [DATA_W-1:0]   pix_d1;
  logic [SYNC_DLY-1:0] de_sr;
  logic [SYNC_DLY-1:0] hs_sr;
  logic [SYNC_DLY-1:0] vs_sr;
  logic [DATA_W-1:0]   ram1_q;
  logic [DATA_W-1:0]   ram2_q;
  logic                de_d1;
  logic                vs_edge;
  logic                de_fall;

  // win[r][c]: r=0 two rows ago, r=2 current row; c=0 oldest column.
  logic [DATA_W-1:0] win     [3][3];
  logic [DATA_W-1:0] win_nxt [3][3];

`ifdef WIN_BORDER_ZERO_EN
  logic [1:0] row_d1;
`endif

  assign de_d1   = de_sr[0];
  assign de_fall = de_d1 & ~pix_de;
  // vs_sr[0] doubles as the previous vsync sample for edge detection.
  assign vs_edge = VS_POL ? (pix_vsync & ~vs_sr[0]) : (~pix_vsync & vs_sr[0]);

  // Column and row position of the pixel currently on the input.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      if (pix_de) begin
        if (col_cnt != COL_MAX) col_cnt <= col_cnt + AW'(1);
      end else begin
        col_cnt <= '0;
      end
      if (vs_edge) begin
        row_cnt <= '0;
      end else if (de_fall && row_cnt != 2'd3) begin
        row_cnt <= row_cnt + 2'd1;
      end
    end
  end

  // Stage-1 registers that travel alongside the RAM read.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      pix_d1 <= '0;
      col_d1 <= '0;
`ifdef WIN_BORDER_ZERO_EN
      row_d1 <= '0;
`endif
    end else begin
      pix_d1 <= pix_data;
      col_d1 <= col_cnt;
`ifdef WIN_BORDER_ZERO_EN
      row_d1 <= row_cnt;
`endif
    end
  end

  // Sync delay lines, running in blanking as well as active video.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      de_sr <= '0;
      hs_sr <= '0;
      vs_sr <= '0;
    end else begin
      de_sr <= {de_sr[SYNC_DLY-2:0], pix_de};
      hs_sr <= {hs_sr[SYNC_DLY-2:0], pix_hsync};
      vs_sr <= {vs_sr[SYNC_DLY-2:0], pix_vsync};
    end
  end

  // ram1 holds the previous row, written with the incoming pixel.
  line_ram #(.DEPTH(H_ACTIVE), .WIDTH(DATA_W), .AW(AW)) u_ram1 (
    .pclk    (pclk),
    .wr_en   (pix_de),
    .wr_addr (col_cnt),
    .wr_data (pix_data),
    .rd_en   (pix_de),
    .rd_addr (col_cnt),
    .rd_data (ram1_q)
  );

  // ram2 holds two rows ago; it takes ram1's displaced value one cycle
  // later, once that value has come out of ram1's read register.
  line_ram #(.DEPTH(H_ACTIVE), .WIDTH(DATA_W), .AW(AW)) u_ram2 (
    .pclk    (pclk),
    .wr_en   (de_d1),
    .wr_addr (col_d1),
    .wr_data (ram1_q),
    .rd_en   (pix_de),
    .rd_addr (col_cnt),
    .rd_data (ram2_q)
  );

  // Next window: shift left and load the new column when stage 1 is valid.
  always_comb begin
    win_nxt = win;
    if (de_d1) begin
      for (int r = 0; r < 3; r++) begin
        win_nxt[r][0] = win[r][1];
        win_nxt[r][1] = win[r][2];
      end
      win_nxt[0][2] = ram2_q;
      win_nxt[1][2] = ram1_q;
      win_nxt[2][2] = pix_d1;
`ifdef WIN_BORDER_ZERO_EN
      // A tap lies above the frame when row+r<2 and left of it when col+c<2.
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          if ((int'(row_d1) + r < 2) || (int'(col_d1) + c < 2)) win_nxt[r][c] = '0;
        end
      end
`endif
    end
  end

  // Window registers.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
      end
    end else begin
      win <= win_nxt;
    end
  end

  assign line11_data  = win[0][0];
  assign line12_data  = win[0][1];
  assign line13_data  = win[0][2];
  assign line21_data  = win[1][0];
  assign line22_data  = win[1][1];
  assign line23_data  = win[1][2];
  assign line31_data  = win[2][0];
  assign line32_data  = win[2][1];
  assign line33_data  = win[2][2];
  assign de_flag_line = de_sr[SYNC_DLY-1];
  assign hsync_line   = hs_sr[SYNC_DLY-1];
  assign vsync_line   = vs_sr[SYNC_DLY-1];

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb/tb_window_3x3_gen.sv - directed bench for window_3x3_gen with H_ACTIVE=4
module tb_window_3x3_gen;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic       pix_de = 1'b0;
  logic       pix_hsync = 1'b0;
  logic       pix_vsync = 1'b0;
  logic [7:0] l11, l12, l13, l21, l22, l23, l31, l32, l33;
  logic       de_o, hs_o, vs_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 pclk = ~pclk;

  window_3x3_gen #(.H_ACTIVE(4), .DATA_W(8), .VS_POL(1'b1)) dut (
    .pclk         (pclk),
    .rst_n        (rst_n),
    .pix_data     (pix_data),
    .pix_de       (pix_de),
    .pix_hsync    (pix_hsync),
    .pix_vsync    (pix_vsync),
    .line11_data  (l11),
    .line12_data  (l12),
    .line13_data  (l13),
    .line21_data  (l21),
    .line22_data  (l22),
    .line23_data  (l23),
    .line31_data  (l31),
    .line32_data  (l32),
    .line33_data  (l33),
    .de_flag_line (de_o),
    .hsync_line   (hs_o),
    .vsync_line   (vs_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Compares all nine taps; exp is {e11,e12,e13,e21,e22,e23,e31,e32,e33}.
  task automatic chk_win(input string tag, input logic [71:0] exp);
    logic [71:0] got;
    got = {l11, l12, l13, l21, l22, l23, l31, l32, l33};
    for (int i = 0; i < 9; i++)
      chk($sformatf("%s_line%0d%0d", tag, i / 3 + 1, i % 3 + 1),
          32'(got[71-8*i -: 8]), 32'(exp[71-8*i -: 8]));
  endtask

  // Applies one cycle of input, then samples 1 time unit after the edge.
  task automatic cyc(input logic de, input logic hs, input logic vs, input logic [7:0] d);
    pix_de    = de;
    pix_hsync = hs;
    pix_vsync = vs;
    pix_data  = d;
    @(posedge pclk);
    #1;
  endtask

  initial begin
    logic pat [6];
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset held with busy inputs: everything must stay at 0.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 8'hFF);
    chk("rst_line33", 32'(l33), 32'h0);
    chk("rst_line22", 32'(l22), 32'h0);
    chk("rst_de", 32'(de_o), 32'h0);
    chk("rst_hsync", 32'(hs_o), 32'h0);
    chk("rst_vsync", 32'(vs_o), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);

    // 3-cycle vsync pulse in blanking, output shifted by two cycles.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, pat[i], 8'h00);
      chk($sformatf("vsync_%0d", i), 32'(vs_o), (i == 0) ? 32'h0 : 32'(pat[i-1]));
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00);

    // 4x4 frame, pixel = 16*row + col.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        cyc(1'b1, 1'b0, 1'b0, 8'(16 * r + c));
        if (r == 0 && c == 0) chk("first_de_t1", 32'(de_o), 32'h0);
        if (r == 0 && c == 1) begin
          chk("first_de_t2", 32'(de_o), 32'h1);
          chk("first_pix_line33", 32'(l33), 32'h00);
        end
        if (r == 2 && c == 1) begin
          chk("r2c0_line13", 32'(l13), 32'h00);
          chk("r2c0_line23", 32'(l23), 32'h10);
          chk("r2c0_line33", 32'(l33), 32'h20);
`ifdef WIN_BORDER_ZERO_EN
          chk("r2c0_line21", 32'(l21), 32'h00);
          chk("r2c0_line22", 32'(l22), 32'h00);
          chk("r2c0_line31", 32'(l31), 32'h00);
          chk("r2c0_line32", 32'(l32), 32'h00);
`else
          chk("r2c0_line21", 32'(l21), 32'h02);
          chk("r2c0_line22", 32'(l22), 32'h03);
          chk("r2c0_line31", 32'(l31), 32'h12);
          chk("r2c0_line32", 32'(l32), 32'h13);
`endif
        end
        if (r == 2 && c == 3)
          chk_win("r2c2", {8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22});
      end
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      if (r == 0) begin
`ifdef WIN_BORDER_ZERO_EN
        chk_win("r0c3", {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03});
`else
        chk("r0c3_line31", 32'(l31), 32'h01);
        chk("r0c3_line32", 32'(l32), 32'h02);
        chk("r0c3_line33", 32'(l33), 32'h03);
`endif
      end
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
    end

    // 3-cycle hsync pulse in blanking.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, pat[i], 1'b0, 8'h00);
      chk($sformatf("hsync_%0d", i), 32'(hs_o), (i == 0) ? 32'h0 : 32'(pat[i-1]));
    end

    // DE overrun: six DE cycles into a 4-pixel line.
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'(8'hA0 + i));
      if (i == 5) chk("ovr_col_sat", 32'(dut.col_cnt), 32'h3);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovr_col_clr", 32'(dut.col_cnt), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, 1'b0, 8'(8'hB0 + c));
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovr_line21", 32'(l21), 32'hA1);
    chk("ovr_line22", 32'(l22), 32'hA2);
    chk("ovr_line23", 32'(l23), 32'hA5);
    chk("ovr_line31", 32'(l31), 32'hB1);
    chk("ovr_line32", 32'(l32), 32'hB2);
    chk("ovr_line33", 32'(l33), 32'hB3);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);

    // Reset in the middle of row 2.
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, 1'b0, 8'(16 * r + c));
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h20);
    cyc(1'b1, 1'b0, 1'b0, 8'h21);
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 8'h22);
    chk_win("midrst", 72'h0);
    chk("midrst_de", 32'(de_o), 32'h0);
    chk("midrst_row", 32'(dut.row_cnt), 32'h0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("newframe_row", 32'(dut.row_cnt), 32'h0);
    for (int c = 0; c < 4; c++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'(8'h30 + c));
      if (c == 1) begin
        chk("newframe_de", 32'(de_o), 32'h1);
        chk("newframe_line33", 32'(l33), 32'h30);
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("newframe_row_inc", 32'(dut.row_cnt), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/window_3x3_gen.md
# window_3x3_gen

Builds the 3×3 pixel neighbourhood consumed by the Sobel stage.
- Accepts a raster grey-scale pixel stream with DE/HSYNC/VSYNC.
- Buffers the two previous active lines in on-chip RAM.
- Presents nine window taps plus sync signals, delay-matched to the window.
- Sits between the grey-conversion stage and the Sobel edge detector.

## Interface
- H_ACTIVE, 640, active pixels per line; line RAM depth.
- DATA_W, 8, pixel width.
- VS_POL, 1, vsync active level (1 = active-high).
- pclk  in  1  pixel clock.
- rst_n  in  1  reset: rst_n, synchronous, active-low; clock pclk.
- pix_data  in  DATA_W  input pixel, valid when pix_de=1.
- pix_de  in  1  active-video flag.
- pix_hsync  in  1  horizontal sync, passed through.
- pix_vsync  in  1  vertical sync; its asserting edge starts a frame.
- line11_data … line33_data  out  DATA_W each  window taps.
  - lineRC: R=1 is two rows ago, R=2 the previous row, R=3 the current row.
  - C=1 is the oldest column, C=3 the newest column.
- de_flag_line  out  1  pix_de delayed 2 cycles.
- hsync_line  out  1  pix_hsync delayed 2 cycles.
- vsync_line  out  1  pix_vsync delayed 2 cycles.

## Operation
- col_cnt (clog2(H_ACTIVE) bits):
  - Increments on each pix_de=1 cycle.
  - Clears on any pix_de=0 cycle.
  - Saturates at H_ACTIVE-1; further DE cycles overwrite the last location.
- row_cnt (2 bits):
  - Clears on the asserting edge of pix_vsync.
  - Increments on each falling edge of pix_de, saturating at 3.
- Cycle T, pix_de=1, address col_cnt:
  - Read ram1[col] (previous row) and ram2[col] (two rows ago).
  - Write ram1[col] <= pix_data and ram2[col] <= ram1 read value.
  - This is a read-before-write chain; the same address is read and written in one cycle.
  - pix_data, de, col and row are registered alongside the read.
- Cycle T+1, when de_d1=1:
  - Shift every window row left: lineR1 <= lineR2, lineR2 <= lineR3.
  - Load the new column: line13 <= ram2 data, line23 <= ram1 data, line33 <= pix_d1.
- When de_d1=0, the window holds its value.
- RAM contents are not reset. Counters, window registers and sync delay lines are reset.
- Simultaneous vsync edge and DE falling edge: the clear takes priority, so row_cnt=0.
- Reset mid-frame:
  - All outputs are 0 on the next cycle.
  - Counters restart and the stream resumes at the next DE.
  - The window contains stale RAM data until refilled.

## Timing
- Latency: the pixel accepted at cycle T appears on line33_data at cycle T+2, coincident with de_flag_line=1.
- Throughput: one pixel per clock, no backpressure.
- Sync outputs are exactly 2 cycles behind their inputs in all states, including blanking.
- Reset values: all line*_data = 0, de_flag_line = 0, hsync_line = 0, vsync_line = 0.
- All outputs are registered. RAM read is synchronous with 1-cycle latency.

## Configuration
- WIN_BORDER_ZERO_EN defined:
  - Forces the affected taps to 0 when the window's newest pixel has row_cnt<2 (rows 1 and 2 replaced) or col_cnt<2 (columns 1 and 2 replaced).
  - Only the taps that fall outside the frame are zeroed.
  - Prevents edge artefacts at frame borders.
- WIN_BORDER_ZERO_EN undefined:
  - Taps carry raw RAM and shift-register contents.
  - This includes the previous line's tail and the previous frame's rows.
  - No border logic is synthesised.

## Structure
- Shared package `vga_pkg`:
  - H_ACTIVE default, DATA_W, VS_POL.
  - pixel_t typedef.
  - SYNC_DLY=2 constant, shared with the Sobel stage's delay bookkeeping.
- Sub-module `line_ram`:
  - Simple dual-port RAM, H_ACTIVE×DATA_W, synchronous read, read-first.
  - Instantiated twice.

## Test plan
- Reset hold then release with a 4×4 frame (H_ACTIVE=4, pixel value = 16·row+col):
  - During reset all outputs read 0.
  - First de_flag_line appears 2 cycles after the first pix_de.
- Row 2, col 2 accepted at T:
  - At T+2: line11..13=0x00,0x01,0x02; line21..23=0x10,0x11,0x12; line31..33=0x20,0x21,0x22.
- Sync alignment: pulse pix_hsync for 3 cycles in blanking -> hsync_line is an identical 3-cycle pulse, 2 cycles later. Same check for vsync.
- DE overrun: 6 DE cycles with H_ACTIVE=4 -> col_cnt holds at 3, ram[3] holds the 6th pixel, no address wrap.
- With WIN_BORDER_ZERO_EN, row 0 col 3 -> line1x and line2x all 0; line31..33=0x01,0x02,0x03.
- Reset asserted mid-line 2 -> outputs 0 the next cycle; the following frame starts with row_cnt=0.
